shared_mem_arbiter: RTL and testbench
=====================================

SHARED_MEM_ARBITER -- requirements
Module: shared_mem_arbiter

Interface
REQ-001 SHALL have parameter: ACCESS_CYCLES, 4, number of cycles the OE/WE strobe is held low; legal range 1..15.
REQ-002 SHALL have ports, clock and reset first (name, direction, width, meaning):
- clk_in  input  1  single clock for all logic.
- rst_in  input  1  reset, synchronous, active-high.
- prg_req_in  input  1  PRG requester access request, level.
- prg_we_in  input  1  PRG requester: 1 = write, 0 = read.
- prg_a_in  input  24  PRG requester byte address.
- prg_d_in  input  8  PRG requester write data.
- prg_d_out  output  8  PRG requester read data.
- prg_ack_out  output  1  PRG requester completion pulse.
- chr_req_in, chr_we_in, chr_a_in, chr_d_in, chr_d_out, chr_ack_out  same directions, widths and meanings as the prg_* ports, for the CHR requester.
- mem_a_out  output  23  memory word address.
- mem_d_in  input  16  memory read data.
- mem_d_out  output  16  memory write data.
- mem_d_oe_out  output  1  data-bus output enable.
- mem_ce_n_out, mem_oe_n_out, mem_we_n_out  output  1 each  memory strobes, active-low.
- mem_lb_n_out, mem_ub_n_out  output  1 each  byte-lane enables, active-low.
- busy_out  output  1  high in any state other than IDLE.

Function
REQ-003 SHALL implement states IDLE, SETUP, ACCESS and HOLD.
REQ-004 State transitions:
- IDLE goes to SETUP when any request is high.
- SETUP goes to ACCESS after 1 cycle.
- ACCESS goes to HOLD after ACCESS_CYCLES cycles.
- HOLD goes to IDLE after 1 cycle.
REQ-005 Requests SHALL be sampled in IDLE only. On the grant edge, the winner's we, address and data SHALL be latched; later changes on that requester's inputs SHALL NOT affect the access in flight.
REQ-006 Arbitration when both requesters are high: grant the requester not granted last (round-robin). When one is high, grant it.
REQ-007 mem_a_out SHALL equal latched address bits [23:1].
REQ-008 Byte lanes: latched address bit 0 = 0 drives mem_lb_n_out low (data on bits [7:0]); bit 0 = 1 drives mem_ub_n_out low (data on bits [15:8]). The unused lane SHALL stay high.
REQ-009 Strobes:
- mem_ce_n_out low in SETUP, ACCESS and HOLD.
- mem_oe_n_out (read) or mem_we_n_out (write) low in ACCESS only.
- All three high in IDLE.
REQ-010 For a write, mem_d_out SHALL equal {d, d}. mem_d_oe_out SHALL be high in SETUP, ACCESS and HOLD, and low otherwise and for all reads.
REQ-011 For a read, the selected byte of mem_d_in SHALL be captured on the edge that ends the last ACCESS cycle. It SHALL appear on the granted requester's d_out in the HOLD cycle and hold until that requester's next read completes.
REQ-012 The granted requester's ack SHALL be high for exactly one cycle, in HOLD. If a request is first seen in IDLE at cycle 0, the ack occurs at cycle ACCESS_CYCLES+2.
REQ-013 A request still high after its ack SHALL be treated as a new request. The requester drops req in the ack cycle to avoid a repeat access.
REQ-014 The ACCESS counter SHALL be 4 bits, load ACCESS_CYCLES-1 on entry to ACCESS, and leave at 0 with no wrap.

Reset
REQ-015 While rst_in is high at a clock edge:
- state = IDLE; all mem strobes and lane enables high.
- mem_d_oe_out, both acks and busy_out = 0.
- d_out registers = 8'h00; mem_a_out = 0.
- last-granted = CHR, so PRG wins the first tie.
REQ-016 Reset during SETUP, ACCESS or HOLD SHALL abort the access with no ack issued. The outputs of REQ-015 hold from the next edge.

Configuration
REQ-017 With macro SHARED_MEM_ARB_CHR_PRIORITY_EN defined, CHR SHALL win every tie (fixed priority) and the last-granted register SHALL be omitted. Without it, REQ-006 round-robin applies.

Structure
REQ-018 Package nes_mem_pkg SHALL hold the state typedef (IDLE/SETUP/ACCESS/HOLD) and requester-ID constants (REQ_PRG=0, REQ_CHR=1).
REQ-019 The 2-way grant logic SHALL be the sub-module arb_rr2 (inputs: two requests, last-granted; output: one-hot grant). The macro of REQ-017 selects its behaviour.

Verification
REQ-020 PRG read of 24'h000001 with mem_d_in=16'hA55A, ACCESS_CYCLES=4 -> ub_n low; prg_d_out=8'hA5 with prg_ack_out at cycle 6; chr_ack_out never asserted.
REQ-021 CHR write of 8'h3C to 24'h000100 -> mem_a_out=23'h000080, mem_d_out=16'h3C3C, lb_n low, we_n low for exactly 4 cycles, mem_d_oe_out high for 6 cycles.
REQ-022 PRG and CHR held high together for 4 accesses, macro undefined -> grant order PRG, CHR, PRG, CHR; with SHARED_MEM_ARB_CHR_PRIORITY_EN -> CHR, CHR, CHR, CHR.
REQ-023 rst_in pulsed in the 2nd ACCESS cycle of a PRG read -> no ack; strobes high and busy_out=0 on the next edge; next request proceeds normally.
REQ-024 PRG address changed from 24'h000010 to 24'h000020 one cycle after grant -> mem_a_out stays 23'h000008 for the whole access.

Source files
------------

// File: rtl/nes_mem_pkg.sv
// Shared types for the PRG/CHR memory arbiter: access FSM states and requester IDs.
package nes_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic REQ_PRG = 1'b0;
  localparam logic REQ_CHR = 1'b1;

  // Picks the addressed byte lane out of a 16-bit memory word.
  function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way grant: round-robin on ties, or fixed CHR priority when
// SHARED_MEM_ARB_CHR_PRIORITY_EN is defined. Grant is one-hot, indexed by requester ID.
module arb_rr2
  import nes_mem_pkg::*;
(
  input  logic       req_prg_i,
  input  logic       req_chr_i,
  input  logic       last_gnt_i,
  output logic [1:0] gnt_o
);

`ifdef SHARED_MEM_ARB_CHR_PRIORITY_EN
  logic unused_last;
  assign unused_last = last_gnt_i;
`endif

  always_comb begin
    gnt_o = 2'b00;
    if (req_prg_i && req_chr_i) begin
`ifdef SHARED_MEM_ARB_CHR_PRIORITY_EN
      gnt_o[REQ_CHR] = 1'b1;
`else
      if (last_gnt_i == REQ_CHR) gnt_o[REQ_PRG] = 1'b1;
      else                       gnt_o[REQ_CHR] = 1'b1;
`endif
    end else if (req_prg_i) begin
      gnt_o[REQ_PRG] = 1'b1;
    end else if (req_chr_i) begin
      gnt_o[REQ_CHR] = 1'b1;
    end
  end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Arbitrates PRG and CHR byte requesters onto one 16-bit async SRAM port.
// Define SHARED_MEM_ARB_CHR_PRIORITY_EN for fixed CHR priority instead of round-robin.
module shared_mem_arbiter
  import nes_mem_pkg::*;
#(
  parameter int ACCESS_CYCLES = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        prg_req_in,
  input  logic        prg_we_in,
  input  logic [23:0] prg_a_in,
  input  logic [7:0]  prg_d_in,
  output logic [7:0]  prg_d_out,
  output logic        prg_ack_out,
  input  logic        chr_req_in,
  input  logic        chr_we_in,
  input  logic [23:0] chr_a_in,
  input  logic [7:0]  chr_d_in,
  output logic [7:0]  chr_d_out,
  output logic        chr_ack_out,
  output logic [22:0] mem_a_out,
  input  logic [15:0] mem_d_in,
  output logic [15:0] mem_d_out,
  output logic        mem_d_oe_out,
  output logic        mem_ce_n_out,
  output logic        mem_oe_n_out,
  output logic        mem_we_n_out,
  output logic        mem_lb_n_out,
  output logic        mem_ub_n_out,
  output logic        busy_out
);

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt_id_q, gnt_id_d;
  logic        we_q, we_d;
  logic [23:0] a_q, a_d;
  logic [7:0]  d_q, d_d;
  logic [7:0]  prg_rd_q, prg_rd_d;
  logic [7:0]  chr_rd_q, chr_rd_d;
  logic        last_gnt;
  logic [1:0]  gnt;

`ifdef SHARED_MEM_ARB_CHR_PRIORITY_EN
  assign last_gnt = REQ_CHR;
`else
  logic last_q, last_d;
  assign last_gnt = last_q;
`endif

  arb_rr2 u_arb (
    .req_prg_i  (prg_req_in),
    .req_chr_i  (chr_req_in),
    .last_gnt_i (last_gnt),
    .gnt_o      (gnt)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_id_d = gnt_id_q;
    we_d     = we_q;
    a_d      = a_q;
    d_d      = d_q;
    prg_rd_d = prg_rd_q;
    chr_rd_d = chr_rd_q;
`ifndef SHARED_MEM_ARB_CHR_PRIORITY_EN
    last_d   = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          state_d  = SETUP;
          gnt_id_d = gnt[REQ_CHR] ? REQ_CHR : REQ_PRG;
          we_d     = gnt[REQ_CHR] ? chr_we_in : prg_we_in;
          a_d      = gnt[REQ_CHR] ? chr_a_in  : prg_a_in;
          d_d      = gnt[REQ_CHR] ? chr_d_in  : prg_d_in;
`ifndef SHARED_MEM_ARB_CHR_PRIORITY_EN
          last_d   = gnt[REQ_CHR] ? REQ_CHR : REQ_PRG;
`endif
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = CNT_LOAD;
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
          // Read data is taken on the edge that closes the strobe window.
          if (!we_q) begin
            if (gnt_id_q == REQ_CHR) chr_rd_d = lane_byte(mem_d_in, a_q[0]);
            else                     prg_rd_d = lane_byte(mem_d_in, a_q[0]);
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      gnt_id_q <= REQ_PRG;
      we_q     <= 1'b0;
      a_q      <= 24'd0;
      d_q      <= 8'd0;
      prg_rd_q <= 8'h00;
      chr_rd_q <= 8'h00;
`ifndef SHARED_MEM_ARB_CHR_PRIORITY_EN
      last_q   <= REQ_CHR;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_id_q <= gnt_id_d;
      we_q     <= we_d;
      a_q      <= a_d;
      d_q      <= d_d;
      prg_rd_q <= prg_rd_d;
      chr_rd_q <= chr_rd_d;
`ifndef SHARED_MEM_ARB_CHR_PRIORITY_EN
      last_q   <= last_d;
`endif
    end
  end

  // Ack is masked by reset so an access aborted in HOLD never completes.
  always_comb begin
    busy_out     = (state_q != IDLE);
    mem_ce_n_out = ~busy_out;
    mem_oe_n_out = ~((state_q == ACCESS) && !we_q);
    mem_we_n_out = ~((state_q == ACCESS) && we_q);
    mem_lb_n_out = ~(busy_out && !a_q[0]);
    mem_ub_n_out = ~(busy_out && a_q[0]);
    mem_d_oe_out = busy_out && we_q;
    mem_d_out    = {d_q, d_q};
    mem_a_out    = a_q[23:1];
    prg_ack_out  = (state_q == HOLD) && (gnt_id_q == REQ_PRG) && !rst_in;
    chr_ack_out  = (state_q == HOLD) && (gnt_id_q == REQ_CHR) && !rst_in;
    prg_d_out    = prg_rd_q;
    chr_d_out    = chr_rd_q;
  end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Self-checking bench for shared_mem_arbiter against a transaction-level reference model.
module tb_shared_mem_arbiter;

  localparam int AC = 4;
  localparam logic PRG = 1'b0;
  localparam logic CHR = 1'b1;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        prg_req_in, prg_we_in, chr_req_in, chr_we_in;
  logic [23:0] prg_a_in, chr_a_in;
  logic [7:0]  prg_d_in, chr_d_in, prg_d_out, chr_d_out;
  logic        prg_ack_out, chr_ack_out;
  logic [22:0] mem_a_out;
  logic [15:0] mem_d_in, mem_d_out;
  logic        mem_d_oe_out, mem_ce_n_out, mem_oe_n_out, mem_we_n_out;
  logic        mem_lb_n_out, mem_ub_n_out, busy_out;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic       model_last;
  logic [7:0] exp_prg_dout, exp_chr_dout;
  logic [0:0] grant_q[$];

  always #5 clk_in = ~clk_in;

  shared_mem_arbiter #(.ACCESS_CYCLES(AC)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .prg_req_in(prg_req_in), .prg_we_in(prg_we_in), .prg_a_in(prg_a_in),
    .prg_d_in(prg_d_in), .prg_d_out(prg_d_out), .prg_ack_out(prg_ack_out),
    .chr_req_in(chr_req_in), .chr_we_in(chr_we_in), .chr_a_in(chr_a_in),
    .chr_d_in(chr_d_in), .chr_d_out(chr_d_out), .chr_ack_out(chr_ack_out),
    .mem_a_out(mem_a_out), .mem_d_in(mem_d_in), .mem_d_out(mem_d_out),
    .mem_d_oe_out(mem_d_oe_out), .mem_ce_n_out(mem_ce_n_out),
    .mem_oe_n_out(mem_oe_n_out), .mem_we_n_out(mem_we_n_out),
    .mem_lb_n_out(mem_lb_n_out), .mem_ub_n_out(mem_ub_n_out), .busy_out(busy_out)
  );

  function automatic logic pick(input logic rp, input logic rc);
    if (rp && rc) begin
`ifdef SHARED_MEM_ARB_CHR_PRIORITY_EN
      return CHR;
`else
      return (model_last == CHR) ? PRG : CHR;
`endif
    end
    return rp ? PRG : CHR;
  endfunction

  task automatic model_reset();
    model_last   = CHR;
    exp_prg_dout = 8'h00;
    exp_chr_dout = 8'h00;
  endtask

  task automatic apply_reset();
    rst_in = 1'b1;
    prg_req_in = 1'b0;
    chr_req_in = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    model_reset();
  endtask

  // One arbitrated access from an idle DUT; caller sets we/a/d inputs, called at a negedge.
  task automatic do_txn(input logic rp, input logic rc, input logic [15:0] mw);
    logic win, w_we;
    logic [23:0] w_a;
    logic [7:0] w_d, rd_byte;
    int ce_low, oe_low, we_low, doe_hi, ack_win, ack_lose;
    win  = pick(rp, rc);
    w_we = win ? chr_we_in : prg_we_in;
    w_a  = win ? chr_a_in  : prg_a_in;
    w_d  = win ? chr_d_in  : prg_d_in;
    rd_byte = w_a[0] ? mw[15:8] : mw[7:0];
    ce_low = 0; oe_low = 0; we_low = 0; doe_hi = 0; ack_win = 0; ack_lose = 0;
    prg_req_in = rp;
    chr_req_in = rc;
    mem_d_in   = mw;
    @(posedge clk_in);
    #1;
    // Inputs change after the grant edge; the access in flight must not notice.
    prg_req_in = 1'b0;
    chr_req_in = 1'b0;
    prg_we_in  = 1'($urandom_range(0, 1));
    chr_we_in  = 1'($urandom_range(0, 1));
    prg_a_in   = w_a ^ 24'h000030;
    chr_a_in   = 24'($urandom);
    prg_d_in   = 8'($urandom);
    chr_d_in   = 8'($urandom);
    for (int c = 1; c <= AC + 2; c++) begin
      @(negedge clk_in);
      if (!mem_ce_n_out) ce_low++;
      if (!mem_oe_n_out) oe_low++;
      if (!mem_we_n_out) we_low++;
      if (mem_d_oe_out) doe_hi++;
      if ((win ? chr_ack_out : prg_ack_out)) ack_win++;
      if ((win ? prg_ack_out : chr_ack_out)) ack_lose++;
      checks++;
      if (mem_a_out !== w_a[23:1]) begin
        errors++;
        $display("FAIL addr c=%0d: got %h want %h", c, mem_a_out, w_a[23:1]);
      end
      checks++;
      if ({mem_ub_n_out, mem_lb_n_out} !== {~w_a[0], w_a[0]}) begin
        errors++;
        $display("FAIL lanes c=%0d: ub_n/lb_n got %b%b want %b%b", c,
                 mem_ub_n_out, mem_lb_n_out, ~w_a[0], w_a[0]);
      end
      checks++;
      if (busy_out !== 1'b1) begin
        errors++;
        $display("FAIL busy c=%0d: got %b want 1", c, busy_out);
      end
      if (w_we) begin
        checks++;
        if (mem_d_out !== {w_d, w_d}) begin
          errors++;
          $display("FAIL wdata c=%0d: got %h want %h", c, mem_d_out, {w_d, w_d});
        end
      end
      if (c >= 2 && c <= AC + 1) begin
        checks++;
        if ({mem_oe_n_out, mem_we_n_out} !== {w_we, ~w_we}) begin
          errors++;
          $display("FAIL strobe c=%0d: oe_n/we_n got %b%b want %b%b", c,
                   mem_oe_n_out, mem_we_n_out, w_we, ~w_we);
        end
      end
      if (c == AC + 2) begin
        if (!w_we) begin
          if (win == CHR) exp_chr_dout = rd_byte;
          else            exp_prg_dout = rd_byte;
        end
        checks++;
        if ((win ? chr_ack_out : prg_ack_out) !== 1'b1) begin
          errors++;
          $display("FAIL ack_time: winner %0d ack got 0 want 1 at cycle %0d", win, c);
        end
        checks++;
        if ({prg_d_out, chr_d_out} !== {exp_prg_dout, exp_chr_dout}) begin
          errors++;
          $display("FAIL dout: prg/chr got %h/%h want %h/%h", prg_d_out, chr_d_out,
                   exp_prg_dout, exp_chr_dout);
        end
      end
    end
    @(negedge clk_in);
    checks++;
    if ({busy_out, mem_ce_n_out, prg_ack_out, chr_ack_out} !== 4'b0100) begin
      errors++;
      $display("FAIL idle_after: busy/ce_n/acks got %b%b%b%b want 0100",
               busy_out, mem_ce_n_out, prg_ack_out, chr_ack_out);
    end
    checks++;
    if (ce_low != AC + 2 || oe_low != (w_we ? 0 : AC) || we_low != (w_we ? AC : 0)
        || doe_hi != (w_we ? AC + 2 : 0)) begin
      errors++;
      $display("FAIL counts: ce/oe/we/doe got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
               ce_low, oe_low, we_low, doe_hi, AC + 2, w_we ? 0 : AC, w_we ? AC : 0,
               w_we ? AC + 2 : 0);
    end
    checks++;
    if (ack_win != 1 || ack_lose != 0) begin
      errors++;
      $display("FAIL ack_count: winner %0d loser %0d want 1 and 0", ack_win, ack_lose);
    end
    model_last = win;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    checks++;
    if ({busy_out, mem_ce_n_out, mem_oe_n_out, mem_we_n_out, mem_lb_n_out, mem_ub_n_out,
         mem_d_oe_out, prg_ack_out, chr_ack_out} !== 9'b011111000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 011111000",
               {busy_out, mem_ce_n_out, mem_oe_n_out, mem_we_n_out, mem_lb_n_out,
                mem_ub_n_out, mem_d_oe_out, prg_ack_out, chr_ack_out});
    end
    checks++;
    if ({prg_d_out, chr_d_out, mem_a_out} !== 39'd0) begin
      errors++;
      $display("FAIL reset_data: prg %h chr %h addr %h want zeros",
               prg_d_out, chr_d_out, mem_a_out);
    end
    rst_in = 1'b0;
    model_reset();
  endtask

  task automatic test_read_hi_lane();
    prg_we_in = 1'b0;
    prg_a_in  = 24'h000001;
    do_txn(1'b1, 1'b0, 16'hA55A);
    checks++;
    if (prg_d_out !== 8'hA5) begin
      errors++;
      $display("FAIL read_hi: prg_d_out got %h want a5", prg_d_out);
    end
  endtask

  task automatic test_write_lo_lane();
    chr_we_in = 1'b1;
    chr_a_in  = 24'h000100;
    chr_d_in  = 8'h3C;
    do_txn(1'b0, 1'b1, 16'h0000);
  endtask

  task automatic test_addr_latch();
    prg_we_in = 1'b0;
    prg_a_in  = 24'h000010;
    do_txn(1'b1, 1'b0, 16'($urandom));
  endtask

  task automatic test_round_robin();
    logic exp, got;
    bit found;
    apply_reset();
    prg_we_in = 1'b1; chr_we_in = 1'b1;
    prg_a_in = 24'($urandom); chr_a_in = 24'($urandom);
    prg_req_in = 1'b1; chr_req_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp = pick(1'b1, 1'b1);
      grant_q.push_back(exp);
      found = 0;
      for (int t = 0; t < 20 && !found; t++) begin
        @(negedge clk_in);
        if (prg_ack_out || chr_ack_out) found = 1;
      end
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL rr_timeout: access %0d no ack within 20 cycles", k);
      end else begin
        got = chr_ack_out ? CHR : PRG;
        if (prg_ack_out && chr_ack_out) got = ~grant_q[0];
        if (got !== grant_q.pop_front()) begin
          errors++;
          $display("FAIL rr_order: access %0d got %0d want %0d", k, got, exp);
        end
      end
      model_last = exp;
    end
    prg_req_in = 1'b0;
    chr_req_in = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic test_reset_abort();
    prg_we_in = 1'b0;
    prg_a_in  = 24'($urandom);
    mem_d_in  = 16'($urandom);
    prg_req_in = 1'b1;
    @(posedge clk_in);
    #1;
    prg_req_in = 1'b0;
    for (int c = 1; c <= 3; c++) @(negedge clk_in);
    checks++;
    if (mem_oe_n_out !== 1'b0) begin
      errors++;
      $display("FAIL abort_pre: oe_n got %b want 0", mem_oe_n_out);
    end
    rst_in = 1'b1;
    @(negedge clk_in);
    checks++;
    if ({busy_out, mem_ce_n_out, mem_oe_n_out, mem_we_n_out, prg_ack_out, chr_ack_out,
         prg_d_out} !== {6'b011100, 8'h00}) begin
      errors++;
      $display("FAIL abort: busy/ce/oe/we/acks %b%b%b%b%b%b dout %h want 011100 00",
               busy_out, mem_ce_n_out, mem_oe_n_out, mem_we_n_out, prg_ack_out,
               chr_ack_out, prg_d_out);
    end
    rst_in = 1'b0;
    model_reset();
    prg_we_in = 1'b0;
    prg_a_in  = 24'($urandom);
    do_txn(1'b1, 1'b0, 16'($urandom));
  endtask

  task automatic test_random();
    logic rp, rc;
    for (int n = 0; n < 30; n++) begin
      rp = 1'($urandom_range(0, 1));
      rc = rp ? 1'($urandom_range(0, 1)) : 1'b1;
      prg_we_in = 1'($urandom_range(0, 1));
      chr_we_in = 1'($urandom_range(0, 1));
      prg_a_in  = 24'($urandom);
      chr_a_in  = 24'($urandom);
      prg_d_in  = 8'($urandom);
      chr_d_in  = 8'($urandom);
      do_txn(rp, rc, 16'($urandom));
    end
  endtask

  initial begin
    rst_in = 1'b1;
    prg_req_in = 1'b0; prg_we_in = 1'b0; prg_a_in = '0; prg_d_in = '0;
    chr_req_in = 1'b0; chr_we_in = 1'b0; chr_a_in = '0; chr_d_in = '0;
    mem_d_in = '0;
    model_reset();
    test_reset();
    test_read_hi_lane();
    test_write_lo_lane();
    test_addr_latch();
    test_round_robin();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
